regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter ABITS, default 5: address width; the file holds DEPTH = 2**ABITS registers.
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding in the same cycle; 0 disables it.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wea  input  1  write enable, port A.
REQ-007 waa  input  ABITS  write address, port A.
REQ-008 wda  input  WIDTH  write data, port A.
REQ-009 web  input  1  write enable, port B.
REQ-010 wab  input  ABITS  write address, port B.
REQ-011 wdb  input  WIDTH  write data, port B.
REQ-012 iss  input  1  issue strobe: marks register iss_a as busy (pending producer).
REQ-013 iss_a  input  ABITS  issue target address.
REQ-014 ra1, ra2  input  ABITS  read addresses.
REQ-015 rd1, rd2  output  WIDTH  combinational read data.
REQ-016 busy1, busy2  output  1  busy flag of ra1 / ra2.
REQ-017 busy_cnt  output  ABITS+1  number of registers currently busy.

Function
REQ-018 Register 0 SHALL read 0 and never be busy; writes and issues to address 0 are ignored.
REQ-019 On a rising clk edge with wea=1 and waa!=0, reg[waa] SHALL take wda; likewise for port B.
REQ-020 When wea=web=1 and waa==wab, port B SHALL win.
REQ-021 Reads SHALL be combinational: rdN = reg[raN], or 0 when raN==0.
REQ-022 With BYPASS=1, rdN SHALL return the data being written this cycle when raN matches an enabled, nonzero write address, with port B data taking precedence over port A.
REQ-023 With BYPASS=0, rdN SHALL return the pre-edge register contents.
REQ-024 Busy bit per register:
- set on an edge with iss=1 and iss_a!=0;
- cleared on an edge by an enabled write to that address on either port.
REQ-025 Issue and write to the same register on the same edge SHALL leave it busy (set wins).
REQ-026 Issue to a register that is already busy SHALL leave it busy, and busy_cnt SHALL not change.
REQ-027 busyN SHALL be combinational, reflect the registered busy bit of raN, and be 0 for raN==0; there is no forwarding of busy state.
REQ-028 busy_cnt SHALL be registered and equal the popcount of the busy bits after each edge; the maximum is DEPTH-1 and it SHALL never wrap.
REQ-029 A write to a register that is not busy SHALL update data and SHALL leave busy_cnt unchanged.

Reset
REQ-030 Asserting reset SHALL immediately clear every register to 0, every busy bit to 0, and busy_cnt to 0, independent of clk.
REQ-031 While reset is high, writes and issues SHALL be ignored; rd1, rd2, busy1 and busy2 SHALL read 0.
REQ-032 A reset asserted between edges SHALL discard in-flight state; the first edge after deassertion SHALL operate normally.

Verification
REQ-033 Scenario: reset; then wea=1, waa=5, wda=0xDEADBEEF for 1 cycle; ra1=5 -> rd1=0xDEADBEEF after the edge. With BYPASS=1, rd1 also equals 0xDEADBEEF during the write cycle; with BYPASS=0 it equals 0 during that cycle.
REQ-034 Scenario: wea=web=1, waa=wab=7, wda=0x1, wdb=0x2 -> reg7=0x2; during the cycle, with BYPASS=1, rd1(ra1=7)=0x2.
REQ-035 Scenario: iss=1, iss_a=3 -> busy1(ra1=3)=1 and busy_cnt=1; then web=1, wab=3 -> busy1=0 and busy_cnt=0.
REQ-036 Scenario: reg 9 busy, then on one edge iss_a=9 with wea=1, waa=9, wda=0x55 -> reg9=0x55, busy stays 1, busy_cnt unchanged.
REQ-037 Scenario: write 0xFFFF to address 0 and issue to address 0 -> rd1(ra1=0)=0, busy1=0, busy_cnt=0.
REQ-038 Scenario: issue to registers 1..31 over 31 cycles -> busy_cnt=31. Then assert reset mid-cycle -> busy_cnt=0, all busy flags 0, all reads 0 immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two write ports, two combinational read ports and a
// scoreboard of busy (pending-producer) bits with a registered busy count.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int ABITS  = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wea,
    input  logic [ABITS-1:0] waa,
    input  logic [WIDTH-1:0] wda,
    input  logic             web,
    input  logic [ABITS-1:0] wab,
    input  logic [WIDTH-1:0] wdb,
    input  logic             iss,
    input  logic [ABITS-1:0] iss_a,
    input  logic [ABITS-1:0] ra1,
    input  logic [ABITS-1:0] ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    output logic [ABITS:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ABITS;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [ABITS:0]   cnt_next;

    logic             wa_en;
    logic             wb_en;
    logic             iss_en;

    // Address 0 is hard-wired to zero, so every write/issue to it is dropped.
    assign wa_en  = wea && (waa != '0);
    assign wb_en  = web && (wab != '0);
    assign iss_en = iss && (iss_a != '0);

    // NOTE: the data array is reset as well, because a reset must make every
    // read return 0 immediately; this rules out a plain RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; the later port B update
            // overrides port A when both target the same register.
            if (wa_en) regs[waa] <= wda;
            if (wb_en) regs[wab] <= wdb;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < DEPTH; i++) begin
            if ((wa_en && waa == ABITS'(i)) || (wb_en && wab == ABITS'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (iss_en && iss_a == ABITS'(i)) begin
                busy_next[i] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Count is rebuilt from the next-state vector rather than incremented, so
    // it cannot drift or wrap regardless of how set/clear events combine.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (ABITS + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    logic [ABITS-1:0] ra_p [2];
    assign ra_p[0] = ra1;
    assign ra_p[1] = ra2;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic [WIDTH-1:0] rd;
        logic             bz;

        // Busy state is never forwarded; only write data may bypass.
        always_comb begin
            rd = '0;
            bz = 1'b0;
            if (!reset && ra_p[p] != '0) begin
                rd = regs[ra_p[p]];
                bz = busy[ra_p[p]];
                if (BYPASS != 0) begin
                    if (wb_en && wab == ra_p[p]) begin
                        rd = wdb;
                    end else if (wa_en && waa == ra_p[p]) begin
                        rd = wda;
                    end
                end
            end
        end
    end

    assign rd1   = g_read[0].rd;
    assign rd2   = g_read[1].rd;
    assign busy1 = g_read[0].bz;
    assign busy2 = g_read[1].bz;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with forwarding, one without,
// sharing the same stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        wea, web, iss;
    logic [4:0]  waa, wab, iss_a, ra1, ra2;
    logic [31:0] wda, wdb;
    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        busy1, busy2, busy1_nb, busy2_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.WIDTH(32), .ABITS(5), .BYPASS(1)) u_bp (
        .clk(clk), .reset(reset),
        .wea(wea), .waa(waa), .wda(wda),
        .web(web), .wab(wab), .wdb(wdb),
        .iss(iss), .iss_a(iss_a),
        .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.WIDTH(32), .ABITS(5), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset),
        .wea(wea), .waa(waa), .wda(wda),
        .web(web), .wab(wab), .wdb(wdb),
        .iss(iss), .iss_a(iss_a),
        .ra1(ra1), .ra2(ra2),
        .rd1(rd1_nb), .rd2(rd2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb),
        .busy_cnt(busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wea = 1'b0; waa = '0; wda = '0;
        web = 1'b0; wab = '0; wdb = '0;
        iss = 1'b0; iss_a = '0;
    endtask

    typedef struct {
        logic        wea;
        logic [4:0]  waa;
        logic [31:0] wda;
        logic        web;
        logic [4:0]  wab;
        logic [31:0] wdb;
        logic        iss;
        logic [4:0]  iss_a;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] d_rd1;     // before the edge, forwarding instance
        logic [31:0] d_rd2;
        logic [31:0] d_rd1_nb;  // before the edge, non-forwarding instance
        logic [31:0] q_rd1;     // after the edge, write enables dropped
        logic [31:0] q_rd2;
        logic        q_busy1;
        logic        q_busy2;
        logic [5:0]  q_cnt;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    initial begin
        logic [5:0] prev_cnt;

        //            wea waa  wda           web wab  wdb           iss ia    ra1   ra2    d_rd1         d_rd2         d_rd1_nb      q_rd1         q_rd2         b1    b2    cnt
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1] = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2,       1'b0, 5'd0, 5'd7, 5'd5, 32'h2,        32'hDEADBEEF, 32'h0,        32'h2,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 5'd3, 5'd3, 5'd7, 32'h0,        32'h2,        32'h0,        32'h0,        32'h2,        1'b1, 1'b0, 6'd1};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33,      1'b0, 5'd0, 5'd3, 5'd3, 32'h33,       32'h33,       32'h0,        32'h33,       32'h33,       1'b0, 1'b0, 6'd0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 5'd9, 5'd9, 5'd3, 32'h0,        32'h33,       32'h0,        32'h0,        32'h33,       1'b1, 1'b0, 6'd1};
        vecs[5] = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 32'h0,       1'b1, 5'd9, 5'd9, 5'd9, 32'h55,       32'h55,       32'h0,        32'h55,       32'h55,       1'b1, 1'b1, 6'd1};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 5'd9, 5'd9, 5'd9, 32'h55,       32'h55,       32'h55,       32'h55,       32'h55,       1'b1, 1'b1, 6'd1};
        vecs[7] = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,       1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h55,       32'h0,        32'h0,        32'h55,       1'b0, 1'b1, 6'd1};
        vecs[8] = '{1'b1, 5'd5, 32'h12345678, 1'b1, 5'd9, 32'hA5,      1'b0, 5'd0, 5'd5, 5'd9, 32'h12345678, 32'hA5,       32'hDEADBEEF, 32'h12345678, 32'hA5,       1'b0, 1'b0, 6'd0};
        vecs[9] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd31, 5'd1, 32'hCAFEF00D, 32'h11,      32'h0,        32'hCAFEF00D, 32'h11,       1'b1, 1'b0, 6'd1};

        // Power-on reset
        idle_inputs();
        reset = 1'b1;
        ra1 = 5'd5; ra2 = 5'd31;
        @(posedge clk); #1;
        check("reset rd1", rd1, 32'h0);
        check("reset rd2", rd2, 32'h0);
        check("reset busy1", 32'(busy1), 32'h0);
        check("reset cnt", 32'(busy_cnt), 32'h0);
        reset = 1'b0;
        #1;

        // Table-driven single-edge vectors
        prev_cnt = 6'd0;
        for (int i = 0; i < NVEC; i++) begin
            wea = vecs[i].wea; waa = vecs[i].waa; wda = vecs[i].wda;
            web = vecs[i].web; wab = vecs[i].wab; wdb = vecs[i].wdb;
            iss = vecs[i].iss; iss_a = vecs[i].iss_a;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            check($sformatf("v%0d pre rd1", i), rd1, vecs[i].d_rd1);
            check($sformatf("v%0d pre rd2", i), rd2, vecs[i].d_rd2);
            check($sformatf("v%0d pre rd1 nobypass", i), rd1_nb, vecs[i].d_rd1_nb);
            check($sformatf("v%0d pre cnt", i), 32'(busy_cnt), 32'(prev_cnt));
            @(posedge clk); #1;
            idle_inputs();
            #1;
            check($sformatf("v%0d rd1", i), rd1, vecs[i].q_rd1);
            check($sformatf("v%0d rd2", i), rd2, vecs[i].q_rd2);
            check($sformatf("v%0d rd1 nobypass", i), rd1_nb, vecs[i].q_rd1);
            check($sformatf("v%0d busy1", i), 32'(busy1), 32'(vecs[i].q_busy1));
            check($sformatf("v%0d busy2", i), 32'(busy2), 32'(vecs[i].q_busy2));
            check($sformatf("v%0d cnt", i), 32'(busy_cnt), 32'(vecs[i].q_cnt));
            prev_cnt = vecs[i].q_cnt;
        end

        // Fill the scoreboard: only register 31 is busy at this point
        for (int a = 1; a < 32; a++) begin
            iss = 1'b1; iss_a = 5'(a);
            @(posedge clk); #1;
            if (a == 15) check("fill cnt at 15", 32'(busy_cnt), 32'd16);
        end
        iss = 1'b0;
        #1;
        check("fill cnt full", 32'(busy_cnt), 32'd31);
        iss = 1'b1; iss_a = 5'd31;
        @(posedge clk); #1;
        iss = 1'b0;
        check("reissue at full cnt", 32'(busy_cnt), 32'd31);
        ra1 = 5'd0; ra2 = 5'd20;
        #1;
        check("full busy1 reg0", 32'(busy1), 32'h0);
        check("full busy2 reg20", 32'(busy2), 32'h1);

        // Mid-cycle reset with writes/issues pending: cleared without an edge
        wea = 1'b1; waa = 5'd4; wda = 32'h44;
        iss = 1'b1; iss_a = 5'd4;
        #2;
        reset = 1'b1;
        #1;
        check("async rst cnt", 32'(busy_cnt), 32'h0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #0.1;
            check($sformatf("async rst rd1 r%0d", a), rd1, 32'h0);
            check($sformatf("async rst busy1 r%0d", a), 32'(busy1), 32'h0);
            check($sformatf("async rst rd2 r%0d", 31 - a), rd2, 32'h0);
            check($sformatf("async rst busy2 r%0d", 31 - a), 32'(busy2), 32'h0);
        end
        ra1 = 5'd4; ra2 = 5'd1;
        @(posedge clk); #1;
        check("edge in reset rd1", rd1, 32'h0);
        check("edge in reset rd1 nobypass", rd1_nb, 32'h0);
        check("edge in reset busy1", 32'(busy1), 32'h0);
        check("edge in reset cnt", 32'(busy_cnt), 32'h0);

        // Deassert between edges; the very next edge must act normally
        #2;
        reset = 1'b0;
        iss = 1'b0;
        #1;
        check("post rst pre rd1", rd1, 32'h44);
        check("post rst pre rd1 nobypass", rd1_nb, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("post rst rd1", rd1_nb, 32'h44);
        check("post rst rd2 cleared", rd2, 32'h0);
        check("post rst cnt", 32'(busy_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
